// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: transmitter state encoding,
// frame geometry and the idle level of the serial line.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // A UART line rests at mark (logic high) between frames.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small synchronous byte FIFO with registered occupancy flags. A push that
// finds the FIFO full is accepted only if a pop happens on the same edge;
// otherwise the byte is discarded and `drop` pulses for that cycle.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push         write strobe, push_data written at the write pointer
//   pop          read strobe, advances the read pointer (ignored when empty)
//   head         byte at the read pointer (valid while !empty)
//   count        current occupancy, 0..DEPTH
//   full, empty  registered occupancy flags
//   drop         combinational pulse: push refused because the FIFO is full
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && !empty_q;
    // A pop on the same edge frees the slot the push is about to use.
    push_ok  = push && (!full_q || pop_ok);
    drop     = push && full_q && !pop_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries data only; stale entries are unreachable after reset
  // because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffers a one-cycle byte strobe stream in a FIFO and serialises it onto a
// UART TX line (8N1, LSB first). The producer cannot be stalled, so bytes
// arriving while the FIFO is full are dropped and a sticky flag is raised.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   in_byte       byte from the producer
//   in_byte_en    one-cycle write strobe
//   overflow_clr  synchronous clear of the overflow flag
//   txd           registered serial output, idles high
//   busy          frame in flight or bytes still queued
//   fifo_count    FIFO occupancy
//   fifo_full     fifo_count == FIFO_DEPTH
//   overflow      sticky: at least one byte was dropped
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter  int CLK_DIV    = 868,
  parameter  int FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_byte,
  input  logic          in_byte_en,
  input  logic          overflow_clr,
  output logic          txd,
  output logic          busy,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          overflow
);

  import uart_pkg::*;

  localparam int              BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          overflow_q, overflow_d;
  logic          baud_done;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          fifo_empty;
  logic          fifo_drop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_byte_en),
    .push_data (in_byte),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    baud_done = (baud_q == BAUD_LAST);
    // The baud counter free-runs inside a frame and restarts at every bit
    // boundary; it is held at zero while idle.
    baud_d    = (baud_done || state_q == IDLE) ? '0 : baud_q + BW'(1);

    unique case (state_q)
      IDLE: begin
        txd_d = LINE_IDLE;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx_q == LAST_BIT) begin
            txd_d   = LINE_IDLE;
            state_d = STOP;
          end else begin
            // shift_q[1] is the next bit once the register moves right.
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shift_d = fifo_head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      txd_q      <= LINE_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  // Shift register holds payload only; it is always reloaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign txd      = txd_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the SoC byte-output port: takes the one-cycle `out_byte`/`out_byte_en` strobe stream and buffers it in a small FIFO.
- Serialises buffered bytes onto a UART TX line: 8N1 framing, LSB first.
- Has no backpressure toward the producer. The producer cannot stall, so bytes that arrive while the FIFO is full are dropped and flagged.
- Sits between the CPU subsystem and the board TX pin.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200). Legal values ≥ 2.
- FIFO_DEPTH, 16, byte entries in the FIFO. Power of two, ≥ 2.
- CW, $clog2(FIFO_DEPTH+1), width of the fill-count output (derived, not overridden).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_byte  input  8  byte from the producer (connects to out_byte).
- in_byte_en  input  1  one-cycle write strobe (connects to out_byte_en).
- overflow_clr  input  1  synchronous clear of the sticky overflow flag.
- txd  output  1  UART serial output; idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  CW  current FIFO occupancy.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- overflow  output  1  sticky flag: a byte was dropped.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high.
- Reset values: txd=1, busy=0, fifo_count=0, fifo_full=0, overflow=0. FSM goes to IDLE, baud counter and bit index go to 0.
- Reset mid-frame: txd returns high immediately (asynchronously). FIFO contents are discarded and the partial frame is abandoned.
- Push:
  - At each clk edge where in_byte_en=1 and the FIFO is not full, in_byte is written at the write pointer.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Full and push:
  - A push on a full FIFO with no pop in the same cycle drops the byte and sets overflow=1.
  - A push on a full FIFO that coincides with a pop is accepted; count is unchanged.
- Push and pop together on a non-full FIFO: count is unchanged and both pointers advance.
- Overflow flag:
  - overflow_clr=1 clears overflow on the next edge.
  - If a drop happens in the same cycle as overflow_clr, the set wins.
- FSM states: IDLE, START, DATA, STOP. Registered baud counter counts 0..CLK_DIV-1. Bit index is 0..7.
- IDLE:
  - If fifo_count != 0, pop the FIFO head into an 8-bit shift register, drive txd<=0, clear the baud counter and go to START.
  - Otherwise txd stays 1.
- START: after CLK_DIV cycles, txd<=shift[0] and go to DATA with bit index 0.
- DATA:
  - Every CLK_DIV cycles, shift right and increment the bit index.
  - txd carries bit i for exactly CLK_DIV cycles.
  - After bit 7, txd<=1 and go to STOP.
- STOP:
  - After CLK_DIV cycles, if the FIFO is non-empty, pop, drive txd<=0 and go directly to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Latency:
  - A strobe sampled at edge E0 into an empty FIFO with the FSM in IDLE sets fifo_count=1 after E0.
  - The FSM pops at E1, so txd is low from E1.
  - The frame lasts exactly 10*CLK_DIV cycles.
- Throughput: a sustained stream produces one frame per 10*CLK_DIV cycles.
- Output timing: txd is registered (glitch-free). busy = (state != IDLE) | (fifo_count != 0).
- Byte order: bytes are transmitted in push order. No reordering and no duplication.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP);
  - localparams for frame bits (DATA_BITS=8, FRAME_BITS=10);
  - the idle-line level constant.
- Sub-module byte_fifo (parameter DEPTH) provides:
  - synchronous write/read, registered count and full/empty;
  - a drop output pulse on push-when-full-without-pop.
- The top level holds the FSM, baud counter, shift register and overflow flag.

Test Plan:
- Single byte, CLK_DIV=4: strobe 0x55 → txd low from E1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy high for E1..E1+39, low after.
- Back-to-back: strobes 0xA5 then 0x3C on consecutive cycles → two frames totalling 80 cycles with no high gap between the stop bit and the second start bit; decoded bytes are A5, 3C.
- Overflow, FIFO_DEPTH=4, CLK_DIV=4: 7 strobes on E0..E6 (0x01..0x07):
  - fifo_count reaches 4 at E4;
  - bytes 0x06 and 0x07 are dropped and overflow=1;
  - txd emits 01,02,03,04,05 only.
- Overflow clear: pulse overflow_clr with no concurrent drop → overflow=0. Repeat with a drop in the same cycle → overflow stays 1.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued:
  - txd=1 immediately and fifo_count=0;
  - after release, txd stays high and busy=0 until the next strobe.
- Pointer wrap, FIFO_DEPTH=4: stream 12 bytes spaced one frame apart → all 12 transmitted in order; fifo_count never exceeds 1.
